// File: rtl/port_tx_arb_if.sv
// AXI-S beat bundle for the port TX arbiter: one instance per source and one for the
// upstream link. KEEP_W is derived from DATA_W.
interface port_tx_arb_if #(
  parameter int DATA_W = 512,
  parameter int USER_W = 10
);
  localparam int KEEP_W = DATA_W / 8;

  logic              tvalid;
  logic              tready;
  logic              tlast;
  logic [DATA_W-1:0] tdata;
  logic [KEEP_W-1:0] tkeep;
  logic [USER_W-1:0] tuser_vendor;

  modport master (output tvalid, tlast, tdata, tkeep, tuser_vendor, input tready);
  modport slave  (input tvalid, tlast, tdata, tkeep, tuser_vendor, output tready);
endinterface

// File: rtl/port_tx_arb.sv
// Packet-atomic 2:1 TX arbiter (MMIO priority, bounded AFU starvation), one registered output stage.
// Optional packet counters: define PORT_TX_ARB_STATS_EN.
module port_tx_arb #(
  parameter int DATA_W     = 512,
  parameter int USER_W     = 10,
  parameter int MMIO_BURST = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  port_tx_arb_if.slave         mmio,
  port_tx_arb_if.slave         afu,
  port_tx_arb_if.master        tx,
  input  logic                 i_block_afu,
  output logic                 o_afu_idle,
  output logic [31:0]          o_mmio_pkt_cnt,
  output logic [31:0]          o_afu_pkt_cnt
);
  typedef enum logic [1:0] {IDLE, MMIO, AFU} state_t;

  typedef struct packed {
    logic                  last;
    logic [DATA_W-1:0]     data;
    logic [DATA_W/8-1:0]   keep;
    logic [USER_W-1:0]     user;
  } beat_t;

  state_t     state;
  logic [3:0] streak;
  logic       stage_rdy, afu_pick, mmio_pick, grant_mmio, grant_afu;
  logic       mmio_acc, afu_acc, afu_req;
  beat_t      m_b, a_b;

  assign stage_rdy  = ~tx.tvalid | tx.tready;
  assign afu_req    = afu.tvalid & ~i_block_afu;
  // AFU only overrides a waiting MMIO once the streak has reached the burst limit
  assign afu_pick   = afu_req & (~mmio.tvalid | (streak == 4'(MMIO_BURST)));
  assign mmio_pick  = mmio.tvalid & ~afu_pick;
  assign grant_mmio = (state == MMIO) | ((state == IDLE) & mmio_pick);
  assign grant_afu  = (state == AFU)  | ((state == IDLE) & afu_pick);

  assign mmio.tready = stage_rdy & grant_mmio;
  assign afu.tready  = stage_rdy & grant_afu;
  assign mmio_acc    = mmio.tvalid & mmio.tready;
  assign afu_acc     = afu.tvalid & afu.tready;

  assign m_b = {mmio.tlast, mmio.tdata, mmio.tkeep, mmio.tuser_vendor};
  assign a_b = {afu.tlast, afu.tdata, afu.tkeep, afu.tuser_vendor};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      streak     <= '0;
      o_afu_idle <= 1'b1;
      tx.tvalid  <= 1'b0;
    end else begin
      o_afu_idle <= (state != AFU) & ~((state == IDLE) & afu_pick);
      case (state)
        IDLE: begin
          if (mmio_acc) begin
            if (!mmio.tlast) state <= MMIO;
            if (afu_req) streak <= (streak == 4'(MMIO_BURST)) ? streak : streak + 4'd1;
            else         streak <= '0;
          end else if (afu_acc) begin
            if (!afu.tlast) state <= AFU;
            streak <= '0;
          end
        end
        MMIO:    if (mmio_acc && mmio.tlast) state <= IDLE;
        AFU:     if (afu_acc && afu.tlast) state <= IDLE;
        default: state <= IDLE;
      endcase
      if (mmio_acc || afu_acc) tx.tvalid <= 1'b1;
      else if (tx.tready)      tx.tvalid <= 1'b0;
    end
  end

  // Payload is don't-care while tvalid is low, so it carries no reset
  always_ff @(posedge clk) begin
    if (mmio_acc || afu_acc)
      {tx.tlast, tx.tdata, tx.tkeep, tx.tuser_vendor} <= mmio_acc ? m_b : a_b;
  end

`ifdef PORT_TX_ARB_STATS_EN
  logic [31:0] mmio_cnt_q, afu_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mmio_cnt_q <= '0;
      afu_cnt_q  <= '0;
    end else begin
      if (mmio_acc && mmio.tlast) mmio_cnt_q <= mmio_cnt_q + 32'd1;
      if (afu_acc && afu.tlast)   afu_cnt_q  <= afu_cnt_q + 32'd1;
    end
  end

  assign o_mmio_pkt_cnt = mmio_cnt_q;
  assign o_afu_pkt_cnt  = afu_cnt_q;
`else
  assign o_mmio_pkt_cnt = 32'h0;
  assign o_afu_pkt_cnt  = 32'h0;
`endif
endmodule

// File: tb/tb_port_tx_arb.sv
// Scoreboard bench for port_tx_arb: source drivers feed per-port queues, the expected
// upstream beat order is pushed by the stimulus and popped by a negedge monitor.
module tb_port_tx_arb;
  localparam int DATA_W = 64;
  localparam int USER_W = 10;
  localparam int KEEP_W = DATA_W / 8;

  typedef struct {
    logic [DATA_W-1:0] data;
    logic [KEEP_W-1:0] keep;
    logic              last;
    logic [USER_W-1:0] user;
  } beat_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        block_afu = 1'b0;
  logic        afu_idle;
  logic [31:0] mmio_cnt, afu_cnt;
  bit          rdy_toggle = 1'b0;

  beat_t mmio_q[$], afu_q[$], exp_q[$];
  int    n_chk = 0, n_fail = 0, afu_acc_cnt = 0;

  port_tx_arb_if #(.DATA_W(DATA_W), .USER_W(USER_W)) mmio_if ();
  port_tx_arb_if #(.DATA_W(DATA_W), .USER_W(USER_W)) afu_if ();
  port_tx_arb_if #(.DATA_W(DATA_W), .USER_W(USER_W)) tx_if ();

  port_tx_arb #(.DATA_W(DATA_W), .USER_W(USER_W), .MMIO_BURST(4)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .mmio           (mmio_if.slave),
    .afu            (afu_if.slave),
    .tx             (tx_if.master),
    .i_block_afu    (block_afu),
    .o_afu_idle     (afu_idle),
    .o_mmio_pkt_cnt (mmio_cnt),
    .o_afu_pkt_cnt  (afu_cnt)
  );

  always #5 clk = ~clk;

  function automatic beat_t mk(bit src, int id, int b, int n);
    beat_t r;
    r.data = {8'(src), 24'(id), 32'(b)};
    r.keep = (b == n - 1) ? 8'h0F : 8'hFF;
    r.last = (b == n - 1);
    r.user = 10'(id + (src ? 512 : 0));
    return r;
  endfunction

  task automatic send(input bit src, input int id, input int n);
    for (int b = 0; b < n; b++) begin
      if (src) afu_q.push_back(mk(src, id, b, n));
      else     mmio_q.push_back(mk(src, id, b, n));
    end
  endtask

  task automatic expect_pkt(input bit src, input int id, input int n);
    for (int b = 0; b < n; b++) exp_q.push_back(mk(src, id, b, n));
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  task automatic wait_drain(input int max_cyc);
    for (int i = 0; i < max_cyc && exp_q.size() != 0; i++) @(negedge clk);
    if (exp_q.size() != 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL drain_timeout: %0d beats outstanding, want 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  // Source drivers: pop on a handshake seen mid-cycle, present the next beat after the edge
  initial begin
    bit m_fire, a_fire;
    mmio_if.tvalid = 1'b0; mmio_if.tlast = 1'b0; mmio_if.tdata = '0;
    mmio_if.tkeep = '0; mmio_if.tuser_vendor = '0;
    afu_if.tvalid = 1'b0; afu_if.tlast = 1'b0; afu_if.tdata = '0;
    afu_if.tkeep = '0; afu_if.tuser_vendor = '0;
    forever begin
      @(negedge clk);
      m_fire = mmio_if.tvalid & mmio_if.tready;
      a_fire = afu_if.tvalid & afu_if.tready;
      @(posedge clk); #1;
      if (m_fire && mmio_q.size() != 0) void'(mmio_q.pop_front());
      if (a_fire && afu_q.size() != 0) begin void'(afu_q.pop_front()); afu_acc_cnt++; end
      mmio_if.tvalid = (mmio_q.size() != 0);
      if (mmio_q.size() != 0) begin
        mmio_if.tdata = mmio_q[0].data; mmio_if.tkeep = mmio_q[0].keep;
        mmio_if.tlast = mmio_q[0].last; mmio_if.tuser_vendor = mmio_q[0].user;
      end
      afu_if.tvalid = (afu_q.size() != 0);
      if (afu_q.size() != 0) begin
        afu_if.tdata = afu_q[0].data; afu_if.tkeep = afu_q[0].keep;
        afu_if.tlast = afu_q[0].last; afu_if.tuser_vendor = afu_q[0].user;
      end
    end
  end

  initial begin
    tx_if.tready = 1'b1;
    forever begin
      @(posedge clk); #1;
      tx_if.tready = rdy_toggle ? ~tx_if.tready : 1'b1;
    end
  end

  // Monitor: every visible beat must match the scoreboard head, stalled or accepted
  initial begin
    beat_t e;
    forever begin
      @(negedge clk);
      if (rst_n && tx_if.tvalid) begin
        if (exp_q.size() == 0) begin
          if (tx_if.tready) begin
            n_chk++; n_fail++;
            $display("FAIL unexpected_beat: got data=%h, want no beat", tx_if.tdata);
          end
        end else begin
          e = exp_q[0];
          n_chk++;
          if (tx_if.tdata !== e.data || tx_if.tkeep !== e.keep ||
              tx_if.tlast !== e.last || tx_if.tuser_vendor !== e.user) begin
            n_fail++;
            $display("FAIL %s: got data=%h keep=%h last=%b user=%h, want data=%h keep=%h last=%b user=%h",
                     tx_if.tready ? "tx_beat" : "tx_hold", tx_if.tdata, tx_if.tkeep, tx_if.tlast,
                     tx_if.tuser_vendor, e.data, e.keep, e.last, e.user);
          end
          if (tx_if.tready) void'(exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    int base;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    check("rst_tx_tvalid", 32'(tx_if.tvalid), 32'd0);
    check("rst_afu_idle", 32'(afu_idle), 32'd1);
    check("rst_mmio_tready", 32'(mmio_if.tready), 32'd0);
    check("rst_afu_tready", 32'(afu_if.tready), 32'd0);

    // AFU 4-beat packet, MMIO arrives mid-packet and must wait for tlast
    @(posedge clk); #2;
    send(1, 1, 4); expect_pkt(1, 1, 4);
    repeat (3) @(negedge clk);
    check("afu_busy_idle", 32'(afu_idle), 32'd0);
    @(posedge clk); #2;
    send(0, 2, 1); expect_pkt(0, 2, 1);
    wait_drain(100);
    repeat (3) @(negedge clk);
    check("afu_done_idle", 32'(afu_idle), 32'd1);

    // Both always valid: 4 MMIO then 1 AFU, repeating
    @(posedge clk); #2;
    for (int i = 0; i < 8; i++) send(0, 10 + i, 1);
    send(1, 20, 1); send(1, 21, 1);
    for (int i = 0; i < 4; i++) expect_pkt(0, 10 + i, 1);
    expect_pkt(1, 20, 1);
    for (int i = 4; i < 8; i++) expect_pkt(0, 10 + i, 1);
    expect_pkt(1, 21, 1);
    wait_drain(100);

    // Upstream ready toggling every cycle on a 3-beat packet
    @(posedge clk); #2;
    rdy_toggle = 1'b1;
    send(0, 30, 3); expect_pkt(0, 30, 3);
    wait_drain(100);
    @(posedge clk); #2 rdy_toggle = 1'b0;

    // Block asserted after AFU beat 0: packet completes, next AFU packet waits, MMIO served
    @(posedge clk); #2;
    send(1, 40, 3); expect_pkt(1, 40, 3);
    base = afu_acc_cnt;
    for (int i = 0; i < 50 && afu_acc_cnt == base; i++) begin @(posedge clk); #2; end
    check("afu_first_beat_seen", 32'(afu_acc_cnt), 32'(base + 1));
    block_afu = 1'b1;
    send(1, 41, 2);
    send(0, 42, 1); expect_pkt(0, 42, 1);
    wait_drain(100);
    repeat (5) @(negedge clk);
    check("blocked_afu_pending", 32'(afu_q.size()), 32'd2);
    check("blocked_afu_tready", 32'(afu_if.tready), 32'd0);
    check("blocked_afu_idle", 32'(afu_idle), 32'd1);
    @(posedge clk); #2;
    block_afu = 1'b0;
    expect_pkt(1, 41, 2);
    wait_drain(100);

    // Reset, then 3 MMIO + 2 AFU packets for the counters
    @(posedge clk); #2 rst_n = 1'b0;
    @(posedge clk); #2 rst_n = 1'b1;
    @(negedge clk);
    check("rst2_mmio_cnt", mmio_cnt, 32'd0);
    check("rst2_afu_cnt", afu_cnt, 32'd0);
    @(posedge clk); #2;
    send(0, 50, 2); send(0, 51, 1); send(0, 52, 1);
    send(1, 60, 2); send(1, 61, 1);
    expect_pkt(0, 50, 2); expect_pkt(0, 51, 1); expect_pkt(0, 52, 1);
    expect_pkt(1, 60, 2); expect_pkt(1, 61, 1);
    wait_drain(100);
    repeat (2) @(negedge clk);
`ifdef PORT_TX_ARB_STATS_EN
    check("stats_mmio_cnt", mmio_cnt, 32'd3);
    check("stats_afu_cnt", afu_cnt, 32'd2);
    @(posedge clk); #2;
    force dut.mmio_cnt_q = 32'hFFFF_FFFF;
    @(negedge clk);
    release dut.mmio_cnt_q;
    @(posedge clk); #2;
    send(0, 70, 1); expect_pkt(0, 70, 1);
    wait_drain(100);
    repeat (2) @(negedge clk);
    check("stats_mmio_wrap", mmio_cnt, 32'd0);
`else
    check("nostats_mmio_cnt", mmio_cnt, 32'd0);
    check("nostats_afu_cnt", afu_cnt, 32'd0);
`endif

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete, want completion");
    $fatal(1, "timeout");
  end
endmodule
